wc_rr_fifo_arbiter: RTL

Four-requester buffered arbiter. It funnels four 8-bit write streams onto one output channel with valid/ready handshake. Each requester owns an 8-deep FIFO. A work-conserving round-robin scheduler grants only non-empty queues, so no output slots are wasted on idle requesters. It sits between the four producer ports and the single shared downstream consumer.

---
 rtl/wc_rr_fifo_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wc_rr_fifo_arbiter.sv
// Four-requester buffered arbiter: one FIFO per requester feeding a single
// valid/ready output register through a work-conserving round-robin scheduler.
module wc_rr_fifo_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    wen,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    full,
  output logic [3:0]    ovf,
  output logic [DW-1:0] dout,
  output logic [1:0]    src,
  output logic          valid,
  input  logic          ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [4][DEPTH];
  logic [AW-1:0] r_wptr [4];
  logic [AW-1:0] r_rptr [4];
  logic [CW-1:0] r_count [4];
  logic [1:0]    r_ptr;
  logic [1:0]    r_src;
  logic          r_valid;
  logic [DW-1:0] r_dout;
  logic [3:0]    r_ovf;

  logic [DW-1:0] w_wdata [4];
  logic [3:0]    w_full;
  logic [3:0]    w_nonEmpty;
  logic [3:0]    w_push;
  logic [3:0]    w_pop;
  logic          w_slotFree;
  logic          w_grantValid;
  logic [1:0]    w_grantIdx;

  always_comb begin
    w_wdata[0] = a;
    w_wdata[1] = b;
    w_wdata[2] = c;
    w_wdata[3] = d;
  end

  // Fullness and emptiness come from registered counts only, so a queue
  // written this cycle cannot be granted until the next one.
  always_comb begin
    w_full     = '0;
    w_nonEmpty = '0;
    w_push     = '0;
    for (int i = 0; i < 4; i++) begin
      w_full[i]     = (r_count[i] == CW'(DEPTH));
      w_nonEmpty[i] = (r_count[i] != '0);
      w_push[i]     = wen[i] && !w_full[i];
    end
  end

  // Scanning from the farthest candidate back to r_ptr lets the nearest
  // non-empty queue overwrite the others.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_nonEmpty[r_ptr + 2'(k)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = r_ptr + 2'(k);
      end
    end
  end

  assign w_slotFree = !r_valid || ready;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 4; i++) begin
      w_pop[i] = w_slotFree && w_grantValid && (w_grantIdx == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= w_wdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + AW'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + AW'(1);
        end
        if (w_push[i] && !w_pop[i]) begin
          r_count[i] <= r_count[i] + CW'(1);
        end else if (!w_push[i] && w_pop[i]) begin
          r_count[i] <= r_count[i] - CW'(1);
        end
        if (wen[i] && w_full[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  // An idle slot drops valid but keeps the last dout/src visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else if (w_slotFree) begin
      if (w_grantValid) begin
        r_valid <= 1'b1;
        r_dout  <= r_mem[w_grantIdx][r_rptr[w_grantIdx]];
        r_src   <= w_grantIdx;
        r_ptr   <= w_grantIdx + 2'd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign full  = w_full;
  assign ovf   = r_ovf;
  assign dout  = r_dout;
  assign src   = r_src;
  assign valid = r_valid;

endmodule
